// File: rtl/counter_pkg.sv
// Shared counter definitions: arithmetic modes and the next-count/flag rule
// reused by every counter flavour in the codebase.
package counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  typedef struct packed {
    logic [31:0] cnt;
    logic        ovf;
    logic        unf;
  } next_t;

  // Width-generic so counters of any size (up to 32 bits) share one rule; the
  // two extra sum bits hold the sign and the carry past 2^width-1.
  function automatic next_t next_count(input logic [31:0] cur,
                                       input logic        inc,
                                       input logic [31:0] step,
                                       input logic        dec,
                                       input int unsigned width,
                                       input logic        sat);
    next_t              r;
    logic signed [33:0] sum;
    logic signed [33:0] max;
    max   = $signed((34'd1 << width) - 34'd1);
    sum   = $signed({2'b00, cur})
          + (inc ? $signed({2'b00, step}) : 34'sd0)
          - (dec ? 34'sd1 : 34'sd0);
    r.ovf = 1'b0;
    r.unf = 1'b0;
    if (sum > max) begin
      r.ovf = 1'b1;
      r.cnt = sat ? max[31:0] : (sum[31:0] & max[31:0]);
    end else if (sum < 34'sd0) begin
      r.unf = 1'b1;
      r.cnt = sat ? 32'd0 : (sum[31:0] & max[31:0]);
    end else begin
      r.cnt = sum[31:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/step_counter_bank_if.sv
// Control/status bundle of a step_counter_bank: per-channel strobes in,
// registered counts and flags out.
interface step_counter_bank_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int STEP_W   = 2
);
  logic [CHANNELS-1:0]        ld;
  logic [CHANNELS*WIDTH-1:0]  init;
  logic [CHANNELS-1:0]        inc;
  logic [CHANNELS*STEP_W-1:0] step;
  logic [CHANNELS-1:0]        dec;
  logic [CHANNELS-1:0]        clr_flg;
  logic [CHANNELS*WIDTH-1:0]  cnt;
  logic [CHANNELS-1:0]        zero;
  logic [CHANNELS-1:0]        full;
  logic [CHANNELS-1:0]        ovf;
  logic [CHANNELS-1:0]        unf;

  modport master (output ld, init, inc, step, dec, clr_flg,
                  input  cnt, zero, full, ovf, unf);
  modport slave  (input  ld, init, inc, step, dec, clr_flg,
                  output cnt, zero, full, ovf, unf);
endinterface

// File: rtl/step_counter_chan.sv
// One counter channel: count register, sticky ovf/unf flags and the
// zero/full decode of the registered count.
module step_counter_chan
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int STEP_W   = 2,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [WIDTH-1:0]  init,
  input  logic              inc,
  input  logic [STEP_W-1:0] step,
  input  logic              dec,
  input  logic              clr_flg,
  output logic [WIDTH-1:0]  cnt,
  output logic              zero,
  output logic              full,
  output logic              ovf,
  output logic              unf
);

  logic [WIDTH-1:0] cnt_q;
  logic             ovf_q;
  logic             unf_q;
  next_t            nxt;

  always_comb begin
    nxt = next_count(32'(cnt_q), inc, 32'(step), dec, WIDTH, SATURATE == MODE_SAT);
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; rst is checked first so it overrides load and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (ld) begin
      cnt_q <= init;
      if (clr_flg) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end
    end else begin
      // A new event in the same cycle as clr_flg keeps the flag set.
      cnt_q <= WIDTH'(nxt.cnt);
      ovf_q <= nxt.ovf | (ovf_q & ~clr_flg);
      unf_q <= nxt.unf | (unf_q & ~clr_flg);
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);
  assign full = (cnt_q == '1);
  assign ovf  = ovf_q;
  assign unf  = unf_q;

endmodule

// File: rtl/step_counter_bank.sv
// Bank of independent up/down step counters; the top only slices the
// interface buses onto one step_counter_chan per channel.
module step_counter_bank
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int STEP_W   = 2,
  parameter int SATURATE = MODE_WRAP
) (
  input logic                clk,
  input logic                rst,
  step_counter_bank_if.slave bus
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    step_counter_chan #(
      .WIDTH    (WIDTH),
      .STEP_W   (STEP_W),
      .SATURATE (SATURATE)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .ld      (bus.ld[i]),
      .init    (bus.init[i*WIDTH +: WIDTH]),
      .inc     (bus.inc[i]),
      .step    (bus.step[i*STEP_W +: STEP_W]),
      .dec     (bus.dec[i]),
      .clr_flg (bus.clr_flg[i]),
      .cnt     (bus.cnt[i*WIDTH +: WIDTH]),
      .zero    (bus.zero[i]),
      .full    (bus.full[i]),
      .ovf     (bus.ovf[i]),
      .unf     (bus.unf[i])
    );
  end

endmodule
